// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer
// Turns the SPI host byte stream into Logic Sniffer control strobes and
// register-write transactions. Short commands are one byte with bit7 clear.
// Long commands are an opcode with bit7 set, followed by a 4-byte payload
// sent LSB first.
// Optional feature macro: CMD_TIMEOUT_EN. When defined, a long command that
// stalls for TIMEOUT_CYCLES idle cycles is discarded.
module spi_cmd_sequencer #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        capture_done,
  input  logic        tx_busy,
  output logic        cmd_reset,
  output logic        cmd_run,
  output logic        cmd_id,
  output logic        cmd_meta,
  output logic        cmd_rle_finish,
  output logic        wr_valid,
  output logic [7:0]  wr_opcode,
  output logic [31:0] wr_data,
  output logic        armed
);

  // A zero timeout would expire a long command before its first payload byte.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("spi_cmd_sequencer: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic {
    S_OPCODE = 1'b0,
    S_DATA   = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_cnt;
  logic [1:0]  w_cnt_nxt;
  logic [7:0]  r_opcode;
  logic [7:0]  w_opcode_nxt;
  // The top payload byte goes straight into wr_data, so only three bytes are buffered.
  logic [23:0] r_payload;
  logic [23:0] w_payload_nxt;
  logic [7:0]  r_wr_opcode;
  logic [7:0]  w_wr_opcode_nxt;
  logic [31:0] r_wr_data;
  logic [31:0] w_wr_data_nxt;
  logic        r_armed;
  logic        w_armed_nxt;
  logic        r_cmd_reset, w_cmd_reset_nxt;
  logic        r_cmd_run, w_cmd_run_nxt;
  logic        r_cmd_id, w_cmd_id_nxt;
  logic        r_cmd_meta, w_cmd_meta_nxt;
  logic        r_cmd_rle_finish, w_cmd_rle_finish_nxt;
  logic        r_wr_valid, w_wr_valid_nxt;

`ifdef CMD_TIMEOUT_EN
  localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  logic [IDLE_W-1:0] r_idle;
  logic [IDLE_W-1:0] w_idle_nxt;
`endif

  // State, assembly and registered-output update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_OPCODE;
      r_cnt            <= 2'd0;
      r_opcode         <= 8'h00;
      r_payload        <= 24'h000000;
      r_wr_opcode      <= 8'h00;
      r_wr_data        <= 32'h0000_0000;
      r_armed          <= 1'b0;
      r_cmd_reset      <= 1'b0;
      r_cmd_run        <= 1'b0;
      r_cmd_id         <= 1'b0;
      r_cmd_meta       <= 1'b0;
      r_cmd_rle_finish <= 1'b0;
      r_wr_valid       <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      r_idle           <= '0;
`endif
    end else begin
      r_state          <= w_state_nxt;
      r_cnt            <= w_cnt_nxt;
      r_opcode         <= w_opcode_nxt;
      r_payload        <= w_payload_nxt;
      r_wr_opcode      <= w_wr_opcode_nxt;
      r_wr_data        <= w_wr_data_nxt;
      r_armed          <= w_armed_nxt;
      r_cmd_reset      <= w_cmd_reset_nxt;
      r_cmd_run        <= w_cmd_run_nxt;
      r_cmd_id         <= w_cmd_id_nxt;
      r_cmd_meta       <= w_cmd_meta_nxt;
      r_cmd_rle_finish <= w_cmd_rle_finish_nxt;
      r_wr_valid       <= w_wr_valid_nxt;
`ifdef CMD_TIMEOUT_EN
      r_idle           <= w_idle_nxt;
`endif
    end
  end

  // Byte decode: next state, payload assembly, strobes and armed tracking
  always_comb begin
    w_state_nxt          = r_state;
    w_cnt_nxt            = r_cnt;
    w_opcode_nxt         = r_opcode;
    w_payload_nxt        = r_payload;
    w_wr_opcode_nxt      = r_wr_opcode;
    w_wr_data_nxt        = r_wr_data;
    w_armed_nxt          = r_armed;
    w_cmd_reset_nxt      = 1'b0;
    w_cmd_run_nxt        = 1'b0;
    w_cmd_id_nxt         = 1'b0;
    w_cmd_meta_nxt       = 1'b0;
    w_cmd_rle_finish_nxt = 1'b0;
    w_wr_valid_nxt       = 1'b0;
`ifdef CMD_TIMEOUT_EN
    w_idle_nxt           = '0;
`endif

    // End of capture disarms. RUN below still sees the pre-update armed
    // value, so a RUN that coincides with capture_done is dropped.
    if (capture_done) begin
      w_armed_nxt = 1'b0;
    end

    if (rx_valid) begin
      case (r_state)
        S_OPCODE: begin
          if (rx_data[7]) begin
            w_opcode_nxt = rx_data;
            w_cnt_nxt    = 2'd0;
            w_state_nxt  = S_DATA;
          end else begin
            case (rx_data[6:0])
              7'h00: begin
                w_cmd_reset_nxt = 1'b1;
                w_armed_nxt     = 1'b0;
              end
              7'h01: begin
                if (!r_armed) begin
                  w_cmd_run_nxt = 1'b1;
                  w_armed_nxt   = 1'b1;
                end
              end
              7'h02: w_cmd_id_nxt         = !tx_busy;
              7'h04: w_cmd_meta_nxt       = !tx_busy;
              7'h05: w_cmd_rle_finish_nxt = 1'b1;
              default: ;
            endcase
          end
        end
        S_DATA: begin
          case (r_cnt)
            2'd0: w_payload_nxt[7:0]   = rx_data;
            2'd1: w_payload_nxt[15:8]  = rx_data;
            2'd2: w_payload_nxt[23:16] = rx_data;
            default: begin
              w_wr_opcode_nxt = r_opcode;
              w_wr_data_nxt   = {rx_data, r_payload};
              w_wr_valid_nxt  = 1'b1;
              w_state_nxt     = S_OPCODE;
            end
          endcase
          w_cnt_nxt = r_cnt + 2'd1;
        end
        default: w_state_nxt = S_OPCODE;
      endcase
    end
`ifdef CMD_TIMEOUT_EN
    // Stalled long command: drop it once the host has been silent too long.
    else if (r_state == S_DATA) begin
      if (r_idle == IDLE_LAST) begin
        w_state_nxt = S_OPCODE;
        w_cnt_nxt   = 2'd0;
      end else begin
        w_idle_nxt = r_idle + 1'b1;
      end
    end
`endif
  end

  assign cmd_reset      = r_cmd_reset;
  assign cmd_run        = r_cmd_run;
  assign cmd_id         = r_cmd_id;
  assign cmd_meta       = r_cmd_meta;
  assign cmd_rle_finish = r_cmd_rle_finish;
  assign wr_valid       = r_wr_valid;
  assign wr_opcode      = r_wr_opcode;
  assign wr_data        = r_wr_data;
  assign armed          = r_armed;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench for spi_cmd_sequencer; honours CMD_TIMEOUT_EN if defined.
module tb_spi_cmd_sequencer;

  logic        clk;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        capture_done;
  logic        tx_busy;
  logic        cmd_reset;
  logic        cmd_run;
  logic        cmd_id;
  logic        cmd_meta;
  logic        cmd_rle_finish;
  logic        wr_valid;
  logic [7:0]  wr_opcode;
  logic [31:0] wr_data;
  logic        armed;

  int n_chk = 0;
  int n_err = 0;
  int n_run = 0;
  int n_rst = 0;
  int n_wr  = 0;
  int snap;

  spi_cmd_sequencer #(.TIMEOUT_CYCLES(16)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .capture_done   (capture_done),
    .tx_busy        (tx_busy),
    .cmd_reset      (cmd_reset),
    .cmd_run        (cmd_run),
    .cmd_id         (cmd_id),
    .cmd_meta       (cmd_meta),
    .cmd_rle_finish (cmd_rle_finish),
    .wr_valid       (wr_valid),
    .wr_opcode      (wr_opcode),
    .wr_data        (wr_data),
    .armed          (armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (cmd_run)   n_run++;
    if (cmd_reset) n_rst++;
    if (wr_valid)  n_wr++;
  end

  function automatic logic [5:0] strobes();
    return {cmd_reset, cmd_run, cmd_id, cmd_meta, cmd_rle_finish, wr_valid};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present one input cycle; on return the outputs reflect that cycle
  task automatic put(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  initial begin
    rst_n        = 1'b0;
    rx_valid     = 1'b0;
    rx_data      = 8'h00;
    capture_done = 1'b0;
    tx_busy      = 1'b0;
    tick();
    tick();
    check("rst_strobes", 32'(strobes()), 32'h0);
    check("rst_armed", 32'(armed), 32'h0);
    check("rst_wr_opcode", 32'(wr_opcode), 32'h0);
    check("rst_wr_data", wr_data, 32'h0);
    rst_n = 1'b1;
    tick();

    // Long command, payload LSB first
    put(1'b1, 8'h81);
    check("long_op_nostrobe", 32'(strobes()), 32'h0);
    put(1'b1, 8'h0F);
    put(1'b1, 8'h00);
    put(1'b1, 8'h0F);
    check("long_partial_nowr", 32'(wr_valid), 32'h0);
    put(1'b1, 8'h00);
    check("long_strobes", 32'(strobes()), 32'h01);
    check("long_wr_opcode", 32'(wr_opcode), 32'h81);
    check("long_wr_data", wr_data, 32'h000F_000F);
    put(1'b0, 8'h00);
    check("long_wr_onecycle", 32'(wr_valid), 32'h0);
    check("long_wr_data_hold", wr_data, 32'h000F_000F);

    // RUN gating by armed
    snap = n_run;
    put(1'b1, 8'h01);
    check("run1_pulse", 32'(cmd_run), 32'h1);
    check("run1_armed", 32'(armed), 32'h1);
    put(1'b1, 8'h01);
    check("run2_dropped", 32'(cmd_run), 32'h0);
    check("run2_armed", 32'(armed), 32'h1);
    capture_done = 1'b1;
    put(1'b0, 8'h00);
    capture_done = 1'b0;
    check("capdone_disarm", 32'(armed), 32'h0);
    put(1'b1, 8'h01);
    check("run3_pulse", 32'(cmd_run), 32'h1);
    check("run3_armed", 32'(armed), 32'h1);
    put(1'b0, 8'h00);
    check("run_count", 32'(n_run - snap), 32'd2);

    // RUN and capture_done together while armed: disarm, no pulse
    capture_done = 1'b1;
    put(1'b1, 8'h01);
    capture_done = 1'b0;
    check("run_cap_nopulse", 32'(cmd_run), 32'h0);
    check("run_cap_armed", 32'(armed), 32'h0);
    // capture_done while disarmed changes nothing
    capture_done = 1'b1;
    put(1'b0, 8'h00);
    capture_done = 1'b0;
    check("cap_idle_armed", 32'(armed), 32'h0);
    check("cap_idle_strobes", 32'(strobes()), 32'h0);

    // Resync: zeros finish the partial command, then decode as reset
    put(1'b1, 8'h01);
    check("resync_arm", 32'(armed), 32'h1);
    snap = n_rst;
    put(1'b1, 8'hC0);
    put(1'b1, 8'hFF);
    put(1'b1, 8'h00);
    put(1'b1, 8'h00);
    check("resync_no_reset_in_data", 32'(cmd_reset), 32'h0);
    put(1'b1, 8'h00);
    check("resync_strobes", 32'(strobes()), 32'h01);
    check("resync_wr_opcode", 32'(wr_opcode), 32'hC0);
    check("resync_wr_data", wr_data, 32'h0000_00FF);
    put(1'b1, 8'h00);
    check("resync_reset4", 32'(strobes()), 32'h20);
    check("resync_disarm", 32'(armed), 32'h0);
    put(1'b1, 8'h00);
    check("resync_reset5", 32'(strobes()), 32'h20);
    put(1'b0, 8'h00);
    check("resync_reset_count", 32'(n_rst - snap), 32'd2);

    // ID/META gated by tx_busy; ignored opcodes
    tx_busy = 1'b1;
    put(1'b1, 8'h02);
    check("id_busy", 32'(strobes()), 32'h0);
    put(1'b1, 8'h04);
    check("meta_busy", 32'(strobes()), 32'h0);
    tx_busy = 1'b0;
    put(1'b1, 8'h02);
    check("id_free", 32'(strobes()), 32'h08);
    put(1'b1, 8'h04);
    check("meta_free", 32'(strobes()), 32'h04);
    put(1'b1, 8'h7F);
    check("filler_ignored", 32'(strobes()), 32'h0);
    put(1'b1, 8'h03);
    check("op03_ignored", 32'(strobes()), 32'h0);
    put(1'b1, 8'h05);
    check("rle_finish", 32'(strobes()), 32'h02);
    put(1'b0, 8'h00);
    check("rle_onecycle", 32'(strobes()), 32'h0);

    // Stalled long command
    snap = n_wr;
    put(1'b1, 8'h82);
    put(1'b1, 8'h00);
    for (int i = 0; i < 16; i++) put(1'b0, 8'h00);
    put(1'b1, 8'h05);
`ifdef CMD_TIMEOUT_EN
    check("timeout_rle", 32'(strobes()), 32'h02);
    put(1'b0, 8'h00);
    check("timeout_no_wr", 32'(n_wr - snap), 32'd0);
`else
    check("notimeout_payload", 32'(strobes()), 32'h0);
    put(1'b1, 8'hAA);
    put(1'b1, 8'hBB);
    check("notimeout_wr", 32'(strobes()), 32'h01);
    check("notimeout_wr_opcode", 32'(wr_opcode), 32'h82);
    check("notimeout_wr_data", wr_data, 32'hBBAA_0500);
    put(1'b0, 8'h00);
`endif

    // Asynchronous reset in the middle of a long command
    put(1'b1, 8'h01);
    check("prereset_armed", 32'(armed), 32'h1);
    put(1'b1, 8'h80);
    put(1'b1, 8'h02);
    rst_n = 1'b0;
    #1;
    check("areset_armed", 32'(armed), 32'h0);
    check("areset_wr_opcode", 32'(wr_opcode), 32'h0);
    check("areset_wr_data", wr_data, 32'h0);
    check("areset_strobes", 32'(strobes()), 32'h0);
    rst_n = 1'b1;
    tick();
    snap = n_wr;
    for (int i = 0; i < 4; i++) begin
      put(1'b1, 8'h00);
      check($sformatf("postreset_rst%0d", i), 32'(strobes()), 32'h20);
    end
    put(1'b0, 8'h00);
    check("postreset_no_wr", 32'(n_wr - snap), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
